// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the dual-port Wishbone SRAM arbiter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int SRAM_AW = 10;
  localparam int SRAM_DW = 32;
  localparam int SRAM_MW = SRAM_DW / 8;
  localparam int ADR_LSB = 2;

  localparam int P_MGMT = 0;
  localparam int P_USR  = 1;

endpackage

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - two-requester round-robin arbiter with one-hot grant
module sram_rr_arbiter
  import sram_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01: o_grant[P_MGMT] = 1'b1;
        2'b10: o_grant[P_USR]  = 1'b1;
        // contention: the port that did not win last time goes first
        2'b11: begin
          if (r_last == 1'(P_USR)) o_grant[P_MGMT] = 1'b1;
          else                     o_grant[P_USR]  = 1'b1;
        end
        default: o_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'(P_USR);
    end else if (|o_grant) begin
      r_last <= o_grant[P_USR];
    end
  end

endmodule

// File: rtl/sram_wb_arbiter.sv
// rtl/sram_wb_arbiter.sv - shares one single-port SRAM macro between two Wishbone classic slaves
module sram_wb_arbiter
  import sram_arb_pkg::state_t, sram_arb_pkg::IDLE, sram_arb_pkg::ACCESS,
         sram_arb_pkg::CAPTURE, sram_arb_pkg::P_USR;
#(
  parameter int AW      = sram_arb_pkg::SRAM_AW,
  parameter int DW      = sram_arb_pkg::SRAM_DW,
  parameter int ADR_LSB = sram_arb_pkg::ADR_LSB
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [DW/8-1:0] wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [DW-1:0]   wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [DW-1:0]   wbs_dat_o,
  input  logic            usr_cyc_i,
  input  logic            usr_stb_i,
  input  logic            usr_we_i,
  input  logic [DW/8-1:0] usr_sel_i,
  input  logic [31:0]     usr_adr_i,
  input  logic [DW-1:0]   usr_dat_i,
  output logic            usr_ack_o,
  output logic [DW-1:0]   usr_dat_o,
  output logic            sram_csb0_o,
  output logic            sram_web0_o,
  output logic [DW/8-1:0] sram_wmask0_o,
  output logic [AW-1:0]   sram_addr0_o,
  output logic [DW-1:0]   sram_din0_o,
  input  logic [DW-1:0]   sram_dout0_i,
  output logic [1:0]      grant_o
);

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_gnt, w_gnt_nxt, w_gnt;
  logic            r_csb, w_csb_nxt;
  logic            r_web, w_web_nxt;
  logic            r_we, w_we_nxt;
  logic            r_abort, w_abort_nxt;
  logic            r_wbs_ack, w_wbs_ack_nxt;
  logic            r_usr_ack, w_usr_ack_nxt;
  logic [DW/8-1:0] r_wmask, w_wmask_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [DW-1:0]   r_din, w_din_nxt;
  logic [DW-1:0]   r_wbs_dat, w_wbs_dat_nxt;
  logic [DW-1:0]   r_usr_dat, w_usr_dat_nxt;

  logic            w_wbs_req, w_usr_req, w_arb_en;
  logic            w_req_we;
  logic [DW/8-1:0] w_req_sel;
  logic [31:0]     w_req_adr;
  logic [DW-1:0]   w_req_dat;
  logic            w_own_usr, w_own_cyc;
  logic            w_unused;

  // A port whose ack is on the bus this cycle is still holding stb; keep it out of arbitration.
  assign w_wbs_req = wbs_cyc_i & wbs_stb_i & ~r_wbs_ack;
  assign w_usr_req = usr_cyc_i & usr_stb_i & ~r_usr_ack;
  assign w_arb_en  = (r_state == IDLE);

  sram_rr_arbiter u_arb (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_en    (w_arb_en),
    .i_req   ({w_usr_req, w_wbs_req}),
    .o_grant (w_gnt)
  );

  assign w_req_we  = w_gnt[P_USR] ? usr_we_i  : wbs_we_i;
  assign w_req_sel = w_gnt[P_USR] ? usr_sel_i : wbs_sel_i;
  assign w_req_adr = w_gnt[P_USR] ? usr_adr_i : wbs_adr_i;
  assign w_req_dat = w_gnt[P_USR] ? usr_dat_i : wbs_dat_i;
  assign w_own_usr = r_gnt[P_USR];
  assign w_own_cyc = w_own_usr ? usr_cyc_i : wbs_cyc_i;

  assign w_unused = ^{wbs_adr_i[31:ADR_LSB+AW], wbs_adr_i[ADR_LSB-1:0],
                      usr_adr_i[31:ADR_LSB+AW], usr_adr_i[ADR_LSB-1:0]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_gnt     <= 2'b00;
      r_csb     <= 1'b1;
      r_web     <= 1'b1;
      r_we      <= 1'b0;
      r_abort   <= 1'b0;
      r_wmask   <= '0;
      r_addr    <= '0;
      r_din     <= '0;
      r_wbs_ack <= 1'b0;
      r_usr_ack <= 1'b0;
      r_wbs_dat <= '0;
      r_usr_dat <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_csb     <= w_csb_nxt;
      r_web     <= w_web_nxt;
      r_we      <= w_we_nxt;
      r_abort   <= w_abort_nxt;
      r_wmask   <= w_wmask_nxt;
      r_addr    <= w_addr_nxt;
      r_din     <= w_din_nxt;
      r_wbs_ack <= w_wbs_ack_nxt;
      r_usr_ack <= w_usr_ack_nxt;
      r_wbs_dat <= w_wbs_dat_nxt;
      r_usr_dat <= w_usr_dat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_gnt) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_csb_nxt     = r_csb;
    w_web_nxt     = r_web;
    w_we_nxt      = r_we;
    w_abort_nxt   = r_abort;
    w_wmask_nxt   = r_wmask;
    w_addr_nxt    = r_addr;
    w_din_nxt     = r_din;
    w_wbs_ack_nxt = 1'b0;
    w_usr_ack_nxt = 1'b0;
    w_wbs_dat_nxt = r_wbs_dat;
    w_usr_dat_nxt = r_usr_dat;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_gnt_nxt   = w_gnt;
          w_csb_nxt   = 1'b0;
          w_web_nxt   = ~w_req_we;
          w_we_nxt    = w_req_we;
          w_abort_nxt = 1'b0;
          w_wmask_nxt = w_req_we ? w_req_sel : '0;
          w_addr_nxt  = w_req_adr[ADR_LSB+AW-1:ADR_LSB];
          w_din_nxt   = w_req_dat;
        end
      end
      ACCESS: begin
        w_csb_nxt   = 1'b1;
        w_web_nxt   = 1'b1;
        w_wmask_nxt = '0;
        w_abort_nxt = ~w_own_cyc;
      end
      CAPTURE: begin
        w_gnt_nxt = 2'b00;
        // the macro access has already happened; only the bus-side result is dropped on abort
        if (!r_abort && w_own_cyc) begin
          if (w_own_usr) begin
            w_usr_ack_nxt = 1'b1;
            if (!r_we) w_usr_dat_nxt = sram_dout0_i;
          end else begin
            w_wbs_ack_nxt = 1'b1;
            if (!r_we) w_wbs_dat_nxt = sram_dout0_i;
          end
        end
      end
      default: w_gnt_nxt = 2'b00;
    endcase
  end

  assign sram_csb0_o   = r_csb;
  assign sram_web0_o   = r_web;
  assign sram_wmask0_o = r_wmask;
  assign sram_addr0_o  = r_addr;
  assign sram_din0_o   = r_din;
  assign wbs_ack_o     = r_wbs_ack;
  assign usr_ack_o     = r_usr_ack;
  assign wbs_dat_o     = r_wbs_dat;
  assign usr_dat_o     = r_usr_dat;
  assign grant_o       = r_gnt;

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// tb/tb_sram_wb_arbiter.sv - directed scoreboard bench for sram_wb_arbiter with a behavioural SRAM
module tb_sram_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        usr_cyc_i, usr_stb_i, usr_we_i;
  logic [3:0]  usr_sel_i;
  logic [31:0] usr_adr_i, usr_dat_i;
  logic        usr_ack_o;
  logic [31:0] usr_dat_o;
  logic        sram_csb0_o, sram_web0_o;
  logic [3:0]  sram_wmask0_o;
  logic [9:0]  sram_addr0_o;
  logic [31:0] sram_din0_o;
  logic [31:0] sram_dout0_i = 32'h0;
  logic [1:0]  grant_o;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_wb_arbiter dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .usr_cyc_i     (usr_cyc_i),
    .usr_stb_i     (usr_stb_i),
    .usr_we_i      (usr_we_i),
    .usr_sel_i     (usr_sel_i),
    .usr_adr_i     (usr_adr_i),
    .usr_dat_i     (usr_dat_i),
    .usr_ack_o     (usr_ack_o),
    .usr_dat_o     (usr_dat_o),
    .sram_csb0_o   (sram_csb0_o),
    .sram_web0_o   (sram_web0_o),
    .sram_wmask0_o (sram_wmask0_o),
    .sram_addr0_o  (sram_addr0_o),
    .sram_din0_o   (sram_din0_o),
    .sram_dout0_i  (sram_dout0_i),
    .grant_o       (grant_o)
  );

  // behavioural macro: data appears after the edge that sampled csb0=0
  logic [31:0] sram_mem [0:1023];
  always @(posedge clk) begin
    if (!sram_csb0_o) begin
      if (!sram_web0_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0_o[b]) sram_mem[sram_addr0_o][8*b +: 8] <= sram_din0_o[8*b +: 8];
      end else begin
        sram_dout0_i <= sram_mem[sram_addr0_o];
      end
    end
  end

  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];

  int          cyc_n = 0;
  int          csb_cnt = 0;
  int          usr_ack_cnt = 0;
  int          overlap = 0;
  logic [9:0]  mon_addr;
  logic [3:0]  mon_wmask;
  logic [1:0]  gnt_log [$];
  int          ack0_t [$];
  int          ack1_t [$];

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (!sram_csb0_o) begin
      csb_cnt++;
      mon_addr  = sram_addr0_o;
      mon_wmask = sram_wmask0_o;
      gnt_log.push_back(grant_o);
    end
    if (wbs_ack_o && usr_ack_o) overlap++;
    if (usr_ack_o) usr_ack_cnt++;
    if (wbs_ack_o) ack0_t.push_back(cyc_n);
    if (usr_ack_o) ack1_t.push_back(cyc_n);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic c, input logic s, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (p == 0) begin
      wbs_cyc_i = c; wbs_stb_i = s; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    end else begin
      usr_cyc_i = c; usr_stb_i = s; usr_we_i = we; usr_adr_i = adr; usr_dat_i = dat; usr_sel_i = sel;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? wbs_ack_o : usr_ack_o;
  endfunction

  function automatic logic [31:0] dat_of(input int p);
    return (p == 0) ? wbs_dat_o : usr_dat_o;
  endfunction

  task automatic txn(input int p, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input bit cont, output int lat);
    logic [31:0] e;
    int w;
    if (!cont) @(negedge clk);
    w = int'(adr[11:2]);
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
    end else if (p == 0) begin
      exp0.push_back(ref_mem[w]);
    end else begin
      exp1.push_back(ref_mem[w]);
    end
    drive(p, 1'b1, 1'b1, we, adr, dat, sel);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack_of(p) && lat < 20);
    chk($sformatf("ack_seen_p%0d", p), 32'(ack_of(p)), 32'd1);
    if (!cont) drive(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    if (!we) begin
      e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
      chk($sformatf("rd_data_p%0d", p), dat_of(p), e);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_csb"},   32'(sram_csb0_o),   32'd1);
    chk({tag, "_web"},   32'(sram_web0_o),   32'd1);
    chk({tag, "_wmask"}, 32'(sram_wmask0_o), 32'd0);
    chk({tag, "_addr"},  32'(sram_addr0_o),  32'd0);
    chk({tag, "_din"},   sram_din0_o,        32'd0);
    chk({tag, "_ack0"},  32'(wbs_ack_o),     32'd0);
    chk({tag, "_ack1"},  32'(usr_ack_o),     32'd0);
    chk({tag, "_dat0"},  wbs_dat_o,          32'd0);
    chk({tag, "_dat1"},  usr_dat_o,          32'd0);
    chk({tag, "_grant"}, 32'(grant_o),       32'd0);
  endtask

  initial begin
    int lat, l0, l1, c0, a0;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    rst_chk("reset");
    rst = 1'b0;

    // port 0 full-word write then read back
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, lat);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_addr", 32'(mon_addr), 32'd4);
    chk("wr_wmask", 32'(mon_wmask), 32'hF);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, lat);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_addr", 32'(mon_addr), 32'd4);

    // port 1 byte-lane merge
    txn(1, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, lat);
    txn(1, 1'b1, 32'h0000_0020, 32'h0000_00AA, 4'h1, 1'b0, lat);
    chk("byte_wmask", 32'(mon_wmask), 32'h1);
    txn(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, lat);
    chk("byte_rd_lat", 32'(lat), 32'd3);

    // sel=0 write still accesses the macro and acks, but changes nothing
    c0 = csb_cnt;
    txn(1, 1'b1, 32'h0000_0020, 32'h5555_5555, 4'h0, 1'b0, lat);
    chk("sel0_csb_pulse", 32'(csb_cnt - c0), 32'd1);
    chk("sel0_wmask", 32'(mon_wmask), 32'h0);
    txn(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, lat);

    // address wrap at the top of the word space
    txn(0, 1'b1, 32'h0000_0FFC, 32'hA1A1_A1A1, 4'hF, 1'b0, lat);
    chk("wrap_addr_hi", 32'(mon_addr), 32'd1023);
    txn(0, 1'b1, 32'h0000_1000, 32'hB2B2_B2B2, 4'hF, 1'b0, lat);
    chk("wrap_addr_lo", 32'(mon_addr), 32'd0);
    txn(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0, lat);
    txn(0, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 1'b0, lat);

    // port 1 aborts during ACCESS
    c0 = csb_cnt;
    a0 = usr_ack_cnt;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    @(negedge clk);
    chk("abort_in_access", 32'(sram_csb0_o), 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    chk("abort_csb_pulses", 32'(csb_cnt - c0), 32'd1);
    chk("abort_no_ack", 32'(usr_ack_cnt - a0), 32'd0);
    chk("abort_dat_kept", usr_dat_o, 32'h1122_33AA);
    chk("abort_idle_grant", 32'(grant_o), 32'd0);
    txn(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0, lat);
    chk("post_abort_lat", 32'(lat), 32'd3);

    // asynchronous reset while a write is in ACCESS
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0077, 4'hF);
    @(negedge clk);
    chk("mid_in_access", 32'(sram_csb0_o), 32'd0);
    rst = 1'b1;
    #1;
    rst_chk("midrst");
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    // both ports stream reads: strict alternation starting with port 0
    gnt_log.delete();
    ack0_t.delete();
    ack1_t.delete();
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 3; i++) txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, l0);
      end
      begin
        for (int i = 0; i < 3; i++) txn(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b1, l1);
      end
    join
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("rr_grants", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < gnt_log.size(); i++)
      chk($sformatf("rr_grant_%0d", i), 32'(gnt_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    chk("rr_acks0", 32'(ack0_t.size()), 32'd3);
    chk("rr_acks1", 32'(ack1_t.size()), 32'd3);
    for (int i = 1; i < ack0_t.size(); i++)
      chk($sformatf("rr_period0_%0d", i), 32'(ack0_t[i] - ack0_t[i-1]), 32'd6);
    for (int i = 1; i < ack1_t.size(); i++)
      chk($sformatf("rr_period1_%0d", i), 32'(ack1_t[i] - ack1_t[i-1]), 32'd6);
    chk("ack_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
